// File: rtl/io_pad_array.sv
// Configurable GPIO pad array: per-pad mode/invert/edge-detect registers behind a
// single config page, with 2-flop input synchronisers and sticky edge status.
module io_pad_array #(
    parameter int unsigned NUM_PADS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         config_addr,
    input  logic [31:0]         config_data,
    input  logic                config_en,
    input  logic                config_we,
    output logic [31:0]         config_read_data,
    output logic                config_read_valid,
    input  logic [NUM_PADS-1:0] pad_in,
    output logic [NUM_PADS-1:0] pad_out,
    output logic [NUM_PADS-1:0] pad_oe,
    input  logic [NUM_PADS-1:0] fabric_in,
    output logic [NUM_PADS-1:0] fabric_out,
    output logic                edge_irq
);

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_IN       = 2'b01,
        MODE_OUT_COMB = 2'b10,
        MODE_OUT_REG  = 2'b11
    } pad_mode_e;

    localparam logic [7:0] STATUS_OFFSET = 8'h40;

    // Per-pad config word: [1:0] mode, [2] invert, [3] rise enable, [4] fall enable
    logic [NUM_PADS-1:0][4:0] cfg_q, cfg_d;
    logic [NUM_PADS-1:0]      status_q, status_d;
    logic [NUM_PADS-1:0]      sync1_q, sync1_d;
    logic [NUM_PADS-1:0]      sync2_q, sync2_d;
    logic [NUM_PADS-1:0]      hist_q, hist_d;
    logic [NUM_PADS-1:0]      oreg_q, oreg_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [31:0]              rd_data_q, rd_data_d;

    logic                     hit;
    logic [7:0]               offset;
    logic                     wr_hit;
    logic                     rd_hit;

    logic [NUM_PADS-1:0]      inv_vec;
    logic [NUM_PADS-1:0]      in_en;
    logic [NUM_PADS-1:0]      comb_en;
    logic [NUM_PADS-1:0]      reg_en;
    logic [NUM_PADS-1:0]      rise_en;
    logic [NUM_PADS-1:0]      fall_en;
    logic [NUM_PADS-1:0]      s_vec;
    logic [NUM_PADS-1:0]      edge_set;
    logic [NUM_PADS-1:0]      status_clr;
    logic [31:0]              rd_value;

    // Only the low config_data bits reach registers; fold the rest into a sink.
    logic                     unused_data;
    assign unused_data = ^config_data;

    assign hit    = (config_addr[31:8] == BASE_ADDR[31:8]);
    assign offset = config_addr[7:0];
    assign wr_hit = config_en & config_we & hit;
    assign rd_hit = config_en & ~config_we & hit;

    always_comb begin
        inv_vec = '0;
        in_en   = '0;
        comb_en = '0;
        reg_en  = '0;
        rise_en = '0;
        fall_en = '0;
        for (int unsigned i = 0; i < NUM_PADS; i++) begin
            inv_vec[i] = cfg_q[i][2];
            rise_en[i] = cfg_q[i][3];
            fall_en[i] = cfg_q[i][4];
            case (pad_mode_e'(cfg_q[i][1:0]))
                MODE_IN:       in_en[i]   = 1'b1;
                MODE_OUT_COMB: comb_en[i] = 1'b1;
                MODE_OUT_REG:  reg_en[i]  = 1'b1;
                default:       ;
            endcase
        end
    end

    assign s_vec    = sync2_q ^ inv_vec;
    assign edge_set = in_en & ((rise_en & s_vec & ~hist_q) | (fall_en & ~s_vec & hist_q));

    always_comb begin
        cfg_d = cfg_q;
        for (int unsigned i = 0; i < NUM_PADS; i++) begin
            if (wr_hit && (offset == 8'(i))) begin
                cfg_d[i] = config_data[4:0];
            end
        end
    end

    // A fresh edge is ORed in after the clear so it survives a same-cycle W1C.
    always_comb begin
        status_clr = '0;
        if (wr_hit && (offset == STATUS_OFFSET)) begin
            status_clr = config_data[NUM_PADS-1:0];
        end
        status_d = (status_q & ~status_clr) | edge_set;
    end

    always_comb begin
        rd_value = '0;
        for (int unsigned i = 0; i < NUM_PADS; i++) begin
            if (offset == 8'(i)) begin
                rd_value = {27'b0, cfg_q[i]};
            end
        end
        if (offset == STATUS_OFFSET) begin
            rd_value[NUM_PADS-1:0] = status_q;
        end
    end

    always_comb begin
        rd_valid_d = rd_hit;
        rd_data_d  = rd_hit ? rd_value : '0;
        sync1_d    = pad_in;
        sync2_d    = sync1_q;
        hist_d     = s_vec;
        oreg_d     = fabric_in ^ inv_vec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q      <= '0;
            status_q   <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            hist_q     <= '0;
            oreg_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cfg_q      <= cfg_d;
            status_q   <= status_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hist_q     <= hist_d;
            oreg_q     <= oreg_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign fabric_out        = s_vec & in_en;
    assign pad_oe            = comb_en | reg_en;
    assign pad_out           = (comb_en & (fabric_in ^ inv_vec)) | (reg_en & oreg_q);
    assign edge_irq          = |status_q;
    assign config_read_valid = rd_valid_q;
    assign config_read_data  = rd_data_q;

endmodule
